// File: rtl/memz_pkg.sv
// Shared definitions for the MEMZ slice ring controller: default stage
// encodings, the write-state enumeration and a width helper.
package memz_pkg;

  localparam int unsigned START_LIM_DEF = 4;
  localparam int unsigned REL_STAGE_DEF = 9;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/memz_slice_ctrl_if.sv
// Stage/step inputs and MEMZ status outputs of the slice controller.
interface memz_slice_ctrl_if #(
  parameter int unsigned STAGE_W = 4,
  parameter int unsigned SLC_W   = 2
);

  logic [STAGE_W-1:0] rd_stage;
  logic [STAGE_W-1:0] wr_stage;
  logic               rd_lstep;
  logic               wr_lstep;
  logic               wren_MEMZ;
  logic               slcwraddr_MEMZ;
  logic [SLC_W-1:0]   wrslc_MEMZ;
  logic [SLC_W-1:0]   rdslc_MEMZ;
  logic               full_MEMZ;
  logic               empty_MEMZ;
  logic               stall_MEMZ;
  logic               err_MEMZ;

  modport master (
    output rd_stage, wr_stage, rd_lstep, wr_lstep,
    input  wren_MEMZ, slcwraddr_MEMZ, wrslc_MEMZ, rdslc_MEMZ,
    input  full_MEMZ, empty_MEMZ, stall_MEMZ, err_MEMZ
  );

  modport slave (
    input  rd_stage, wr_stage, rd_lstep, wr_lstep,
    output wren_MEMZ, slcwraddr_MEMZ, wrslc_MEMZ, rdslc_MEMZ,
    output full_MEMZ, empty_MEMZ, stall_MEMZ, err_MEMZ
  );

endinterface

// File: rtl/memz_slice_ring.sv
// Ring bookkeeping for MEMZ slices: write/read pointers and the count of
// committed, unreleased slices.
module memz_slice_ring
  import memz_pkg::*;
#(
  parameter int unsigned NSLC  = 3,
  parameter int unsigned SLC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic             retire,
  output logic [SLC_W-1:0] wr_ptr,
  output logic [SLC_W-1:0] rd_ptr,
  output logic             full,
  output logic             empty,
  output logic             free
);

  localparam int unsigned      OCC_W    = clog2(NSLC + 1);
  localparam logic [SLC_W-1:0] PTR_LAST = SLC_W'(NSLC - 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(NSLC);

  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;

  always_comb begin
    occ_next = occ;
    if (commit && !retire)      occ_next = occ + 1'b1;
    else if (!commit && retire) occ_next = occ - 1'b1;
  end

  // Free-slice check looks at the post-commit/release count so a
  // back-to-back start can claim the slot a same-cycle release opens.
  assign free  = (occ_next < OCC_MAX);
  assign full  = (occ == OCC_MAX);
  assign empty = (occ == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      occ <= occ_next;
      if (commit) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (retire) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/memz_slice_ctrl.sv
// MEMZ slice controller: decodes start/stop/release events, runs the
// write-burst FSM and keeps a sticky protocol error flag.
module memz_slice_ctrl
  import memz_pkg::*;
#(
  parameter int unsigned STAGE_W   = 4,
  parameter int unsigned NSLC      = 3,
  parameter int unsigned SLC_W     = 2,
  parameter int unsigned START_LIM = START_LIM_DEF,
  parameter int unsigned REL_STAGE = REL_STAGE_DEF
) (
  input logic               clk,
  input logic               rst,
  memz_slice_ctrl_if.slave  bus
);

  localparam logic [STAGE_W-1:0] START_V = STAGE_W'(START_LIM);
  localparam logic [STAGE_W-1:0] REL_V   = STAGE_W'(REL_STAGE);

  wr_state_t        state;
  logic             wren;
  logic             err;
  logic             start, stop, rel;
  logic             commit, retire, stall;
  logic             free, full, empty;
  logic [SLC_W-1:0] wr_ptr, rd_ptr;

  assign start = bus.rd_lstep & (bus.rd_stage < START_V);
  assign stop  = bus.wr_lstep & bus.wr_stage[0] & (bus.wr_stage < START_V);
  assign rel   = bus.rd_lstep & (bus.rd_stage == REL_V);

  assign commit = stop & (state == WRITE);
  assign retire = rel & ~empty;
  assign stall  = start & ~free & ((state == IDLE) | stop);

  memz_slice_ring #(
    .NSLC  (NSLC),
    .SLC_W (SLC_W)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .commit (commit),
    .retire (retire),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .full   (full),
    .empty  (empty),
    .free   (free)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wren  <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= err | stall | (stop & (state == IDLE)) | (rel & empty);
      case (state)
        IDLE: begin
          if (start && free) begin
            state <= WRITE;
            wren  <= 1'b1;
          end
        end
        WRITE: begin
          // Stop with a same-cycle start chains into the next slice
          // without a gap; start alone while writing is ignored.
          if (stop && !(start && free)) begin
            state <= IDLE;
            wren  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          wren  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wren_MEMZ      = wren;
  assign bus.slcwraddr_MEMZ = wren & bus.wr_stage[0];
  assign bus.wrslc_MEMZ     = wr_ptr;
  assign bus.rdslc_MEMZ     = rd_ptr;
  assign bus.full_MEMZ      = full;
  assign bus.empty_MEMZ     = empty;
  assign bus.stall_MEMZ     = stall;
  assign bus.err_MEMZ       = err;

endmodule
